// File: rtl/imem_loader.sv
// Packs a little-endian byte stream into 32-bit words and writes them to instruction memory.
// Each word is written the cycle after its 4th byte; byte_ready is high only while collecting.
module imem_loader #(
    parameter int unsigned DEPTH     = 20,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [4:0]  nwords,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        iwr_en,
    output logic [31:0] iaddr,
    output logic [31:0] idata,
    output logic        busy,
    output logic        done,
    output logic        err
);
    localparam int unsigned IW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, COLLECT, WRITE, FINISH} state_t;

    state_t        r_state;
    logic [IW-1:0] r_idx;
    logic [1:0]    r_bcnt;
    logic [4:0]    r_nwords;
    logic [23:0]   r_word;
    logic          r_byte_ready;
    logic          r_iwr_en;
    logic [31:0]   r_iaddr;
    logic [31:0]   r_idata;
    logic          r_busy;
    logic          r_done;
    logic          r_err;

    logic          w_start_ok;
    logic          w_accept;
    logic [IW-1:0] w_idx_next;

    assign w_start_ok = (nwords != 5'd0) && (32'(nwords) <= DEPTH);
    assign w_accept   = byte_valid && r_byte_ready;
    assign w_idx_next = r_idx + IW'(1);

    // The 4th byte bypasses the shift register straight into idata.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_idx        <= '0;
            r_bcnt       <= 2'd0;
            r_nwords     <= 5'd0;
            r_word       <= 24'd0;
            r_byte_ready <= 1'b0;
            r_iwr_en     <= 1'b0;
            r_iaddr      <= 32'd0;
            r_idata      <= 32'd0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_iwr_en <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (w_start_ok) begin
                            r_state      <= COLLECT;
                            r_idx        <= '0;
                            r_bcnt       <= 2'd0;
                            r_nwords     <= nwords;
                            r_byte_ready <= 1'b1;
                            r_busy       <= 1'b1;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                COLLECT: begin
                    if (w_accept) begin
                        r_bcnt <= r_bcnt + 2'd1;
                        case (r_bcnt)
                            2'd0: r_word[7:0]   <= byte_data;
                            2'd1: r_word[15:8]  <= byte_data;
                            2'd2: r_word[23:16] <= byte_data;
                            default: begin
                                r_state      <= WRITE;
                                r_byte_ready <= 1'b0;
                                r_iwr_en     <= 1'b1;
                                r_iaddr      <= BASE_ADDR + 32'({r_idx, 2'b00});
                                r_idata      <= {byte_data, r_word};
                            end
                        endcase
                    end
                end
                WRITE: begin
                    r_idx <= w_idx_next;
                    if (w_idx_next == IW'(r_nwords)) begin
                        r_state <= FINISH;
                        r_done  <= 1'b1;
                    end else begin
                        r_state      <= COLLECT;
                        r_byte_ready <= 1'b1;
                    end
                end
                FINISH: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state      <= IDLE;
                    r_byte_ready <= 1'b0;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

    assign byte_ready = r_byte_ready;
    assign iwr_en     = r_iwr_en;
    assign iaddr      = r_iaddr;
    assign idata      = r_idata;
    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized directed bench for imem_loader; expected writes are derived from the byte list.
module tb_imem_loader;
    localparam int          DEPTH = 20;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [4:0]  nwords;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        iwr_en;
    logic [31:0] iaddr;
    logic [31:0] idata;
    logic        busy;
    logic        done;
    logic        err;

    imem_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .nwords(nwords),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .iwr_en(iwr_en), .iaddr(iaddr), .idata(idata),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] got_addr[$];
    logic [31:0] got_data[$];
    int          wr_cyc[$];
    int          done_cyc[$];
    int          err_cyc[$];
    int          acc_cyc[$];

    always @(negedge clk) begin
        if (iwr_en) begin
            got_addr.push_back(iaddr);
            got_data.push_back(idata);
            wr_cyc.push_back(cyc);
        end
        if (done) done_cyc.push_back(cyc);
        if (err) err_cyc.push_back(cyc);
        if (byte_valid && byte_ready) acc_cyc.push_back(cyc);
    end

    int n_pass   = 0;
    int n_checks = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [4:0] n);
        start  = 1'b1;
        nwords = n;
        tick();
        start  = 1'b0;
        nwords = 5'($urandom);
    endtask

    // mode 0: gap-free, 1: valid toggles every cycle, 2: random gaps
    task automatic feed(input logic [7:0] b[$], input int mode);
        int i = 0;
        bit ph = 1'b1;
        for (int g = 0; g < 4000 && i < b.size(); g++) begin
            case (mode)
                0:       byte_valid = 1'b1;
                1:       byte_valid = ph;
                default: byte_valid = 1'($urandom_range(0, 1));
            endcase
            ph        = ~ph;
            byte_data = b[i];
            @(negedge clk);
            if (byte_valid && byte_ready) i++;
            tick();
        end
        byte_valid = 1'b0;
        byte_data  = 8'($urandom);
        chk("feed_all_bytes", 64'(i), 64'(b.size()));
    endtask

    task automatic check_load(input string tag, input int n, input logic [7:0] b[$],
                              input int mw, input int md, input int me, input int ma);
        logic [31:0] exp_d;
        for (int k = 0; k < 60 && done_cyc.size() == md; k++) tick();
        chk({tag, "_nwrites"}, 64'(got_addr.size() - mw), 64'(n));
        for (int j = 0; j < n && (mw + j) < got_addr.size(); j++) begin
            exp_d = {b[4*j+3], b[4*j+2], b[4*j+1], b[4*j]};
            chk({tag, "_addr"}, 64'(got_addr[mw+j]), 64'(BASE + 32'(4 * j)));
            chk({tag, "_data"}, 64'(got_data[mw+j]), 64'(exp_d));
            if (ma + 4*j + 3 < acc_cyc.size())
                chk({tag, "_wr_lat"}, 64'(wr_cyc[mw+j]), 64'(acc_cyc[ma+4*j+3] + 1));
        end
        chk({tag, "_ndone"}, 64'(done_cyc.size() - md), 64'(1));
        if (done_cyc.size() > md && wr_cyc.size() > mw)
            chk({tag, "_done_lat"}, 64'(done_cyc[md]), 64'(wr_cyc[wr_cyc.size()-1] + 1));
        chk({tag, "_no_err"}, 64'(err_cyc.size() - me), 64'(0));
        chk({tag, "_busy_after"}, 64'(busy), 64'(0));
    endtask

    // inject > 0: a second start (nwords=5) is pulsed after that many bytes
    task automatic run_load(input string tag, input int n, input logic [7:0] b[$],
                            input int mode, input int inject);
        int mw = got_addr.size();
        int md = done_cyc.size();
        int me = err_cyc.size();
        int ma = acc_cyc.size();
        logic [7:0] b1[$];
        logic [7:0] b2[$];
        pulse_start(5'(n));
        chk({tag, "_busy_start"}, 64'(busy), 64'(1));
        if (inject > 0) begin
            for (int i = 0; i < b.size(); i++)
                if (i < inject) b1.push_back(b[i]); else b2.push_back(b[i]);
            feed(b1, mode);
            pulse_start(5'd5);
            feed(b2, mode);
        end else begin
            feed(b, mode);
        end
        check_load(tag, n, b, mw, md, me, ma);
    endtask

    logic [7:0] bq[$];
    int mw0, me0, ma0;

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        nwords     = 5'd0;
        byte_valid = 1'b0;
        byte_data  = 8'd0;
        #3;
        chk("rst_ctrl", 64'({byte_ready, iwr_en, busy, done, err}), 64'(0));
        chk("rst_iaddr", 64'(iaddr), 64'(0));
        chk("rst_idata", 64'(idata), 64'(0));
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // single word, fixed bytes
        bq.delete();
        bq.push_back(8'h13); bq.push_back(8'h00); bq.push_back(8'h00); bq.push_back(8'h00);
        run_load("one_word", 1, bq, 0, 0);

        // three words gap-free, then toggled valid
        bq.delete();
        for (int i = 0; i < 12; i++) bq.push_back(8'($urandom));
        run_load("three_words", 3, bq, 0, 0);
        run_load("toggle_valid", 3, bq, 1, 0);

        // rejected starts: nwords=0 and nwords=DEPTH+1
        mw0 = got_addr.size();
        me0 = err_cyc.size();
        pulse_start(5'd0);
        @(negedge clk);
        chk("err_n0_pulse", 64'(err), 64'(1));
        chk("err_n0_busy", 64'(busy), 64'(0));
        tick();
        chk("err_n0_single", 64'(err), 64'(0));
        pulse_start(5'(DEPTH + 1));
        @(negedge clk);
        chk("err_n21_pulse", 64'(err), 64'(1));
        chk("err_n21_busy", 64'(busy), 64'(0));
        tick();
        chk("err_count", 64'(err_cyc.size() - me0), 64'(2));
        chk("err_no_write", 64'(got_addr.size() - mw0), 64'(0));

        // maximum depth
        bq.delete();
        for (int i = 0; i < 4*DEPTH; i++) bq.push_back(8'($urandom));
        run_load("full_depth", DEPTH, bq, 2, 0);

        // reset after two bytes of the first word
        bq.delete();
        bq.push_back(8'hAA); bq.push_back(8'hBB);
        pulse_start(5'd2);
        feed(bq, 0);
        mw0 = got_addr.size();
        rst_n = 1'b0;
        #1;
        chk("rstc_ctrl", 64'({byte_ready, iwr_en, busy, done, err}), 64'(0));
        chk("rstc_iaddr", 64'(iaddr), 64'(0));
        chk("rstc_idata", 64'(idata), 64'(0));
        tick();
        rst_n = 1'b1;
        ma0 = acc_cyc.size();
        byte_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            byte_data = 8'($urandom);
            tick();
        end
        byte_valid = 1'b0;
        chk("rstc_no_accept", 64'(acc_cyc.size() - ma0), 64'(0));
        chk("rstc_no_write", 64'(got_addr.size() - mw0), 64'(0));
        chk("rstc_idle_busy", 64'(busy), 64'(0));
        bq.delete();
        for (int i = 0; i < 4; i++) bq.push_back(8'($urandom));
        run_load("after_reset", 1, bq, 0, 0);

        // start while busy is ignored
        bq.delete();
        for (int i = 0; i < 8; i++) bq.push_back(8'($urandom));
        run_load("start_busy", 2, bq, 0, 3);

        // reset in the write cycle drops iwr_en at once
        bq.delete();
        for (int i = 0; i < 4; i++) bq.push_back(8'($urandom));
        pulse_start(5'd1);
        feed(bq, 0);
        chk("rstw_wr_seen", 64'(iwr_en), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("rstw_iwr_low", 64'(iwr_en), 64'(0));
        chk("rstw_busy_low", 64'(busy), 64'(0));
        tick();
        rst_n = 1'b1;
        tick();

        // random loads
        for (int t = 0; t < 6; t++) begin
            int n;
            n = $urandom_range(1, DEPTH);
            bq.delete();
            for (int i = 0; i < 4*n; i++) bq.push_back(8'($urandom));
            run_load("rand_load", n, bq, $urandom_range(0, 2), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
